// File: rtl/nios_pipe_pkg.sv
// Shared pipeline types and NIOS encodings used by the operand-supply logic
// and its neighbours in decode/execute.
package nios_pipe_pkg;

    // Destination index field in a slot; sized for the 32-register core.
    localparam int SLOT_RD_W = 5;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [SLOT_RD_W-1:0] rd;
        logic                 is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    typedef enum logic [5:0] {
        OP_ADDI  = 6'h04,
        OP_MOVIA = 6'h05,
        OP_BR    = 6'h06,
        OP_SUBI  = 6'h07,
        OP_STW   = 6'h0F,
        OP_BGT   = 6'h10,
        OP_LDW   = 6'h11,
        OP_RTYPE = 6'h3A
    } opcode_t;

    typedef enum logic [10:0] {
        OPX_MUL = 11'h01B,
        OPX_ADD = 11'h01F
    } opx_t;

endpackage

// File: rtl/nios_regfile.sv
// Architectural register file: two asynchronous operand reads, one debug read
// and one synchronous write, with optional hard-wired zero register.
module nios_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign rd_data_a = is_zero_reg(rd_addr_a) ? '0 : regs[rd_addr_a];
    assign rd_data_b = is_zero_reg(rd_addr_b) ? '0 : regs[rd_addr_b];
    assign dbg_data  = is_zero_reg(dbg_addr)  ? '0 : regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !is_zero_reg(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/nios_operand_fwd_unit.sv
// Operand supply between decode and execute: register file, E/M/W destination
// scoreboard, youngest-first bypass and load-use interlock with stall counter.
module nios_operand_fwd_unit
    import nios_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rd_wr,
    input  logic              id_is_load,
    input  logic              id_flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    slot_t             slot_e_p0, slot_m_p1, slot_w_p2;
    logic [DATA_W-1:0] rf_rs, rf_rt;
    logic              rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;
    logic              issue;
    logic              w_load_unused;

    function automatic logic src_match(input slot_t slot, input logic used,
                                       input logic [ADDR_W-1:0] src);
        return used && slot.valid && slot.wr && (slot.rd == SLOT_RD_W'(src))
               && !((ZERO_REG != 0) && (src == '0));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == '1) ? val : val + 1'b1;
    endfunction

    nios_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (id_rs),
        .rd_addr_b (id_rt),
        .dbg_addr  (dbg_addr),
        .rd_data_a (rf_rs),
        .rd_data_b (rf_rt),
        .dbg_data  (dbg_data),
        .wr_en     (slot_w_p2.valid && slot_w_p2.wr),
        .wr_addr   (ADDR_W'(slot_w_p2.rd)),
        .wr_data   (wb_data)
    );

    // Decode stage: hazard detection and youngest-producer operand select
    assign rs_e = src_match(slot_e_p0, id_rs_used, id_rs);
    assign rs_m = src_match(slot_m_p1, id_rs_used, id_rs);
    assign rs_w = src_match(slot_w_p2, id_rs_used, id_rs);
    assign rt_e = src_match(slot_e_p0, id_rt_used, id_rt);
    assign rt_m = src_match(slot_m_p1, id_rt_used, id_rt);
    assign rt_w = src_match(slot_w_p2, id_rt_used, id_rt);

    assign id_stall = id_valid && !id_flush && slot_e_p0.is_load && (rs_e || rt_e);
    assign issue    = id_valid && !id_stall && !id_flush;
    assign w_load_unused = slot_w_p2.is_load;

    always_comb begin
        id_rs_data = rf_rs;
        if (rs_e)      id_rs_data = ex_result;
        else if (rs_m) id_rs_data = mem_result;
        else if (rs_w) id_rs_data = wb_data;

        id_rt_data = rf_rt;
        if (rt_e)      id_rt_data = ex_result;
        else if (rt_m) id_rt_data = mem_result;
        else if (rt_w) id_rt_data = wb_data;
    end

    // E/M/W scoreboard: slots keep moving during a stall so the load drains to M
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_e_p0 <= SLOT_BUBBLE;
            slot_m_p1 <= SLOT_BUBBLE;
            slot_w_p2 <= SLOT_BUBBLE;
            stall_cnt <= '0;
        end else begin
            slot_e_p0 <= issue ? '{valid: 1'b1, wr: id_rd_wr, rd: SLOT_RD_W'(id_rd),
                                   is_load: id_is_load}
                               : SLOT_BUBBLE;
            slot_m_p1 <= slot_e_p0;
            slot_w_p2 <= slot_m_p1;
            if (id_stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: doc/nios_operand_fwd_unit.md
Name: nios_operand_fwd_unit

Overview:
Parametrised operand-supply block for the in-order 5-stage (F/D/E/M/W) NIOS-style pipeline. It replaces the hard-coded, PC-dependent forwarding of the current core with these parts:
- a general register file;
- a 3-slot destination scoreboard (E/M/W);
- priority bypass from the E, M and W result buses;
- a load-use interlock.

It sits between decode and execute. It also exposes a saturating stall counter for performance debug.

Parameters:
DATA_W, 32, register/data width in bits
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
ZERO_REG, 1, 1 = r0 reads as 0, never written and never matched for bypass or stall
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
id_valid  in  1  decode holds an instruction requesting issue
id_rs  in  ADDR_W  source register A index
id_rt  in  ADDR_W  source register B index
id_rs_used  in  1  source A is read by the instruction
id_rt_used  in  1  source B is read by the instruction
id_rd  in  ADDR_W  destination register index
id_rd_wr  in  1  instruction writes id_rd
id_is_load  in  1  instruction is LDW (result available only in M)
id_flush  in  1  branch taken in E; decode instruction is killed this cycle
ex_result  in  DATA_W  E-stage ALU output, combinational, for the instruction in slot E
mem_result  in  DATA_W  M-stage result after the load mux, for slot M
wb_data  in  DATA_W  W-stage write data, for slot W
id_stall  out  1  hold F/D this cycle
id_rs_data  out  DATA_W  resolved operand A
id_rt_data  out  DATA_W  resolved operand B
stall_cnt  out  CNT_W  count of stall cycles, saturating
dbg_addr  in  ADDR_W  debug read index
dbg_data  out  DATA_W  register file content at dbg_addr, no bypass

Behaviour:
Reset (rst=1 at an edge):
- all slots are invalid;
- all registers are 0;
- stall_cnt is 0.
While the slots are invalid, id_stall=0 and the operand outputs equal the register file contents (0).

Slots:
- Each of E, M and W holds {valid, wr, rd, is_load}.
- issue = id_valid & ~id_stall & ~id_flush.
- Each edge: E <= issue ? {1, id_rd_wr, id_rd, id_is_load} : bubble; M <= E; W <= M.
- Slots advance even while stalled; a stall inserts a bubble into E.

Match rule:
- For source s of slot X: s_used & X.valid & X.wr & (X.rd==s).
- When ZERO_REG=1, s==0 never matches.

Operand priority, resolved per source in the same cycle:
1. E match → ex_result
2. M match → mem_result
3. W match → wb_data
4. otherwise the register file
The youngest producer wins.

Load-use interlock:
- id_stall = id_valid & ~id_flush & (E match on rs or rt where E.is_load).
- id_stall is combinational and deasserts the next cycle because the load has moved to M.
- A load producer matched in M or W is forwarded with no stall.

Writeback:
- At the edge, when W.valid & W.wr and not (ZERO_REG & W.rd==0): reg[W.rd] <= wb_data.
- The value is visible through the register file from the next cycle. Same-cycle reads are covered by the W bypass.

stall_cnt:
- Increments by 1 on each edge with id_stall=1.
- Holds at all-ones (saturates).

id_flush:
- Suppresses issue and stall.
- Does not kill instructions already in E/M/W; those are older than the branch and remain valid.

Reset mid-operation: in-flight slots are discarded and pending writes are lost.

Width: all data paths are DATA_W bits; there is no arithmetic in this block apart from stall_cnt.

Decomposition:
- Shared package nios_pipe_pkg holds:
  - the slot struct type {valid, wr, rd, is_load};
  - the opcode constants (ADDI 0x04, MOVIA 0x05, SUBI 0x07, STW 0x0F, LDW 0x11, R-type 0x3A, BGT 0x10, BR 0x06);
  - the R-type OPX constants (MUL 0x01B, ADD 0x01F).
- Sub-module nios_regfile: NUM_REGS x DATA_W storage with 2 asynchronous read ports, 1 debug read port and 1 synchronous write port, with ZERO_REG handling.

Test Plan:
- After rst, dbg read of r0..r31 → all 0. Issue ADDI r2 with ex_result=0x10, then a dependent read of r2 the next cycle → id_rs_data=0x10 via E bypass, no stall.
- Load-use: LDW r6 issued, next cycle a reader of r6 with id_valid=1 → id_stall=1 for exactly 1 cycle. The following cycle, with mem_result=0x9, id_rs_data=0x9 and stall_cnt=1.
- Priority: r5 writers in W (wb_data=1), M (mem_result=2) and E (ex_result=3) simultaneously → id_rs_data=3. Remove E → 2. Remove M → 1.
- r0: an instruction writes r0 with wb_data=0xFFFF → dbg_data(r0)=0 and a reader of r0 gets 0, no stall even if an E load targets r0.
- Flush: id_flush=1 together with a load-use hazard → id_stall=0 and a bubble enters E. Older M/W slots still write back (r3 becomes 0x5).
- Force 2^CNT_W+3 stall cycles → stall_cnt=0xFFFF. Assert rst mid-stream → stall_cnt=0, slots cleared, no pending writeback occurs.
